// File: rtl/dadda_prod_accumulator.sv
// Frame accumulator for the 4x4 Dadda multiplier's 8-bit products.
// Sums up to COUNT products (or until in_last), saturates on overflow and holds the result until taken.
module dadda_prod_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 10,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] out_count,
  output logic             ovf
);

  typedef enum logic {S_ACC = 1'b0, S_DONE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             r_out_valid;
  logic             w_in_ready;
  logic             w_accept;
  logic [ACC_W:0]   w_sat_sum;

  // Unsigned add with saturation; the MSB of the result flags that it clipped.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [7:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-7){1'b0}}, p};
    sat_add = s[ACC_W] ? {1'b1, {ACC_W{1'b1}}} : s;
  endfunction

  assign w_in_ready = ~rst & (r_state == S_ACC);
  assign w_accept   = in_valid & w_in_ready;
  assign w_sat_sum  = sat_add(r_acc, prod);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_ACC: begin
        if (w_accept) begin
          w_acc_nxt = w_sat_sum[ACC_W-1:0];
          w_ovf_nxt = r_ovf | w_sat_sum[ACC_W];
          w_cnt_nxt = r_cnt + 1'b1;
          if (in_last || (r_cnt == CNT_W'(COUNT - 1)))
            w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Handoff cycle clears the frame; the next accept can only happen one cycle later.
        if (out_ready) begin
          w_state_nxt = S_ACC;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign acc_out   = r_acc;
  assign out_count = r_cnt;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_dadda_prod_accumulator.sv
// Bench for dadda_prod_accumulator: three configurations (default, 8-bit saturating, single-product)
// checked every cycle against a frame-level model, plus directed scenarios with literal expectations.
module tb_dadda_prod_accumulator;

  logic       clk;
  logic       rst;
  logic [2:0] in_valid_v;
  logic [2:0] in_last_v;
  logic [2:0] out_ready_v;
  logic [7:0] prod_a [3];
  logic [2:0] in_ready_v;
  logic [2:0] out_valid_v;
  logic [2:0] ovf_v;

  logic [9:0] acc0;
  logic [7:0] acc1;
  logic [9:0] acc2;
  logic [2:0] cnt0;
  logic [1:0] cnt1;
  logic [0:0] cnt2;

  int checks   = 0;
  int failures = 0;

  localparam int P_COUNT [3] = '{4, 3, 1};
  localparam int P_W     [3] = '{10, 8, 10};

  dadda_prod_accumulator #(.COUNT(4), .ACC_W(10), .CNT_W(3)) u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .prod(prod_a[0]),
    .in_last(in_last_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .acc_out(acc0), .out_count(cnt0), .ovf(ovf_v[0]));

  dadda_prod_accumulator #(.COUNT(3), .ACC_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .prod(prod_a[1]),
    .in_last(in_last_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .acc_out(acc1), .out_count(cnt1), .ovf(ovf_v[1]));

  dadda_prod_accumulator #(.COUNT(1), .ACC_W(10), .CNT_W(1)) u_one (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .prod(prod_a[2]),
    .in_last(in_last_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .acc_out(acc2), .out_count(cnt2), .ovf(ovf_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int acc_of(input int k);
    case (k)
      0:       acc_of = int'(acc0);
      1:       acc_of = int'(acc1);
      default: acc_of = int'(acc2);
    endcase
  endfunction

  function automatic int cnt_of(input int k);
    case (k)
      0:       cnt_of = int'(cnt0);
      1:       cnt_of = int'(cnt1);
      default: cnt_of = int'(cnt2);
    endcase
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t got=%0d want=%0d", name, k, $time, act, exp);
    end
  endtask

  // Frame-level model: raw running sum and product count of the open frame, plus whether it is closed.
  int m_sum  [3] = '{0, 0, 0};
  int m_cnt  [3] = '{0, 0, 0};
  bit m_done [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_done[k] = 1'b0; m_sum[k] = 0; m_cnt[k] = 0;
      end else if (m_done[k]) begin
        if (out_ready_v[k]) begin
          m_done[k] = 1'b0; m_sum[k] = 0; m_cnt[k] = 0;
        end
      end else if (in_valid_v[k]) begin
        m_sum[k] += int'(prod_a[k]);
        m_cnt[k]++;
        if (m_cnt[k] == P_COUNT[k] || in_last_v[k]) m_done[k] = 1'b1;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      int lim;
      lim = (1 << P_W[k]) - 1;
      chk("model_out_valid", k, int'(out_valid_v[k]), int'(m_done[k]));
      chk("model_acc_out", k, acc_of(k), (m_sum[k] > lim) ? lim : m_sum[k]);
      chk("model_out_count", k, cnt_of(k), m_cnt[k]);
      chk("model_ovf", k, int'(ovf_v[k]), (m_sum[k] > lim) ? 1 : 0);
      chk("model_in_ready", k, int'(in_ready_v[k]), (!rst && !m_done[k]) ? 1 : 0);
    end
  end

  task automatic drive(input int k, input logic v, input logic [7:0] p, input logic l);
    in_valid_v[k] = v;
    prod_a[k]     = p;
    in_last_v[k]  = l;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic pat [7];
    rst = 1'b1;
    in_valid_v = '0; in_last_v = '0; out_ready_v = 3'b111;
    for (int k = 0; k < 3; k++) prod_a[k] = 8'd0;
    step(); step();
    chk("reset_out_valid", 0, int'(out_valid_v[0]), 0);
    chk("reset_in_ready", 0, int'(in_ready_v[0]), 0);
    chk("reset_acc", 0, acc_of(0), 0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", 0, int'(in_ready_v[0]), 1);

    // Full frame of 4 x 225
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 8'd225, 1'b0);
      chk("full_in_ready", 0, int'(in_ready_v[0]), 1);
      step();
    end
    drive(0, 1'b0, 8'd0, 1'b0);
    chk("full_acc", 0, acc_of(0), 900);
    chk("full_cnt", 0, cnt_of(0), 4);
    chk("full_ovf", 0, int'(ovf_v[0]), 0);
    chk("full_valid", 0, int'(out_valid_v[0]), 1);
    step();
    chk("full_handoff_valid", 0, int'(out_valid_v[0]), 0);
    chk("full_handoff_ready", 0, int'(in_ready_v[0]), 1);
    chk("full_handoff_acc", 0, acc_of(0), 0);

    // Early termination: 6 then 12 with in_last
    drive(0, 1'b1, 8'd6, 1'b0);  step();
    drive(0, 1'b1, 8'd12, 1'b1); step();
    drive(0, 1'b0, 8'd0, 1'b0);
    chk("early_acc", 0, acc_of(0), 18);
    chk("early_cnt", 0, cnt_of(0), 2);
    chk("early_valid", 0, int'(out_valid_v[0]), 1);
    step();

    // Bubbles on input, then backpressure on output
    out_ready_v[0] = 1'b0;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(0, pat[i], 8'd1, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 8'd9, 1'b1);
      chk("bp_in_ready", 0, int'(in_ready_v[0]), 0);
      chk("bp_acc", 0, acc_of(0), 4);
      chk("bp_cnt", 0, cnt_of(0), 4);
      chk("bp_valid", 0, int'(out_valid_v[0]), 1);
      step();
    end
    out_ready_v[0] = 1'b1;
    step();
    chk("bp_handoff_acc", 0, acc_of(0), 0);
    step();
    drive(0, 1'b0, 8'd0, 1'b0);
    chk("bp_next_acc", 0, acc_of(0), 9);
    chk("bp_next_cnt", 0, cnt_of(0), 1);
    step();

    // Saturation on the 8-bit, COUNT=3 instance
    drive(1, 1'b1, 8'd200, 1'b0); step();
    drive(1, 1'b1, 8'd100, 1'b0); step();
    drive(1, 1'b1, 8'd50, 1'b0);  step();
    drive(1, 1'b0, 8'd0, 1'b0);
    chk("sat_acc", 1, acc_of(1), 255);
    chk("sat_ovf", 1, int'(ovf_v[1]), 1);
    chk("sat_cnt", 1, cnt_of(1), 3);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, 8'd1, 1'b0);
      step();
    end
    drive(1, 1'b0, 8'd0, 1'b0);
    chk("sat_next_acc", 1, acc_of(1), 3);
    chk("sat_next_ovf", 1, int'(ovf_v[1]), 0);
    step();

    // Reset mid-frame
    drive(0, 1'b1, 8'd50, 1'b0); step();
    drive(0, 1'b1, 8'd50, 1'b0); step();
    drive(0, 1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    step();
    chk("rstmid_valid", 0, int'(out_valid_v[0]), 0);
    chk("rstmid_acc", 0, acc_of(0), 0);
    chk("rstmid_cnt", 0, cnt_of(0), 0);
    chk("rstmid_ready", 0, int'(in_ready_v[0]), 0);
    rst = 1'b0;
    out_ready_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 8'd10, 1'b0);
      step();
    end
    drive(0, 1'b0, 8'd0, 1'b0);
    chk("rstmid_next_acc", 0, acc_of(0), 40);
    chk("rstdone_pre_valid", 0, int'(out_valid_v[0]), 1);
    rst = 1'b1;
    step();
    chk("rstdone_valid", 0, int'(out_valid_v[0]), 0);
    chk("rstdone_acc", 0, acc_of(0), 0);
    rst = 1'b0;
    out_ready_v[0] = 1'b1;
    step();

    // Single-product frames
    out_ready_v[2] = 1'b0;
    drive(2, 1'b1, 8'd255, 1'b0); step();
    drive(2, 1'b1, 8'd7, 1'b0);
    chk("one_valid", 2, int'(out_valid_v[2]), 1);
    chk("one_acc", 2, acc_of(2), 255);
    chk("one_cnt", 2, cnt_of(2), 1);
    chk("one_ready", 2, int'(in_ready_v[2]), 0);
    step();
    chk("one_hold_ready", 2, int'(in_ready_v[2]), 0);
    chk("one_hold_acc", 2, acc_of(2), 255);
    drive(2, 1'b0, 8'd0, 1'b0);
    out_ready_v[2] = 1'b1;
    step();
    chk("one_release_ready", 2, int'(in_ready_v[2]), 1);

    // Randomized traffic on all instances; the compare process does the checking
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 3; k++) begin
        logic [7:0] p;
        p = (k == 1 && $urandom_range(0, 1) == 0) ? 8'(200 + $urandom_range(0, 55)) : 8'($urandom_range(0, 255));
        drive(k, 1'($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 7) == 0));
        out_ready_v[k] = 1'($urandom_range(0, 2) != 0);
      end
      step();
    end

    rst = 1'b0;
    in_valid_v = '0;
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
